// File: rtl/button_pkg.sv
// Shared types and constants for the button conditioning blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [1:0] {
    IDLE_UP  = 2'd0,
    CHK_DOWN = 2'd1,
    HELD     = 2'd2,
    CHK_UP   = 2'd3
  } btn_state_t;

  // 10 ms of stable input at a 50 MHz clk.
  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, accept FSM.
// Latency: raw change first sampled at edge E -> pressed/pulse update after edge E+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, outputs are levels and one-cycle strobes.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   btn_raw       raw board pin, asynchronous to clk, may bounce
//   pressed       debounced level, 1 = button held
//   press_pulse   one-cycle strobe when a press is accepted
//   release_pulse one-cycle strobe when a release is accepted
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // Pin level when the button is released; also the synchroniser reset value.
  localparam logic          POL     = (ACTIVE_LOW != 0);

  logic          sync_q1;
  logic          sync_q2;
  logic          s;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          pressed_nxt;
  logic          press_pulse_nxt;
  logic          release_pulse_nxt;

  // s = 1 means "button pressed" regardless of board polarity.
  assign s = sync_q2 ^ POL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1       <= POL;
      sync_q2       <= POL;
      state         <= IDLE_UP;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q1       <= btn_raw;
      sync_q2       <= sync_q1;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pressed       <= pressed_nxt;
      press_pulse   <= press_pulse_nxt;
      release_pulse <= release_pulse_nxt;
    end
  end

  // The counter holds the number of consecutive opposite samples seen so far;
  // the sample that would make it reach DEBOUNCE_CYCLES is the accept, so it
  // never needs to hold more than DEBOUNCE_CYCLES-1.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    pressed_nxt       = pressed;
    press_pulse_nxt   = 1'b0;
    release_pulse_nxt = 1'b0;
    case (state)
      IDLE_UP: begin
        if (s) begin
          state_nxt = CHK_DOWN;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHK_DOWN: begin
        if (!s) begin
          state_nxt = IDLE_UP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt       = HELD;
          pressed_nxt     = 1'b1;
          press_pulse_nxt = 1'b1;
          cnt_nxt         = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = CHK_UP;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_UP: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt         = IDLE_UP;
          pressed_nxt       = 1'b0;
          release_pulse_nxt = 1'b1;
          cnt_nxt           = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt   = IDLE_UP;
        cnt_nxt     = '0;
        pressed_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button conditioner: synchronise, debounce, emit press/release strobes.
// Latency: raw change first sampled at edge E -> outputs update after edge E+DEBOUNCE_CYCLES+1.
// Backpressure: none; every channel is free-running and independent.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   btn_raw       raw board pins [NUM_BUTTONS-1:0], asynchronous, may bounce
//   pressed       debounced levels, 1 = button held
//   press_pulse   one-cycle strobes on accepted press
//   release_pulse one-cycle strobes on accepted release
module button_debounce
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int NB = 2;
  localparam int D  = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] pressed;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;

  logic [NB-1:0] btn2;
  logic [NB-1:0] pressed2;
  logic [NB-1:0] press_pulse2;
  logic [NB-1:0] release_pulse2;

  int checks = 0;
  int errors = 0;

  button_debounce #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  button_debounce #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) dut_hi (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn2),
    .pressed       (pressed2),
    .press_pulse   (press_pulse2),
    .release_pulse (release_pulse2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the active-low DUT. A pin value is seen by the
  // acceptance rule two clock edges after it is sampled. The accepted level
  // flips once D consecutive seen samples disagree with it; any agreeing
  // sample throws the run away.
  bit            m_seen1 [NB];
  bit            m_seen2 [NB];
  bit            m_lvl   [NB];
  int            m_run   [NB];
  bit            m_s;
  logic [NB-1:0] m_pressed;
  logic [NB-1:0] m_pp;
  logic [NB-1:0] m_rp;

  task automatic model_clear();
    for (int ch = 0; ch < NB; ch++) begin
      m_seen1[ch] = 1'b0;
      m_seen2[ch] = 1'b0;
      m_lvl[ch]   = 1'b0;
      m_run[ch]   = 0;
    end
    m_pressed = '0;
    m_pp      = '0;
    m_rp      = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        for (int ch = 0; ch < NB; ch++) begin
          m_s          = m_seen2[ch];
          m_seen2[ch]  = m_seen1[ch];
          m_seen1[ch]  = ~btn_raw[ch];
          m_pp[ch]     = 1'b0;
          m_rp[ch]     = 1'b0;
          if (m_s != m_lvl[ch]) begin
            m_run[ch] = m_run[ch] + 1;
            if (m_run[ch] == D) begin
              m_lvl[ch] = m_s;
              m_run[ch] = 0;
              if (m_s) m_pp[ch] = 1'b1;
              else     m_rp[ch] = 1'b1;
            end
          end else begin
            m_run[ch] = 0;
          end
          m_pressed[ch] = m_lvl[ch];
        end
      end
    end
  end

  // Advance n rising edges, then settle on the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pressed, press_pulse, release_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %b expected 000000", {pressed, press_pulse, release_pulse});
    end
    checks++;
    if (pressed2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_pressed_hi: got %b expected 00", pressed2);
    end
    wait_edges(2);
    reset = 1'b0;
    // Hold both buttons until accepted, then reset mid-cycle.
    btn_raw = 2'b00;
    wait_edges(8);
    checks++;
    if (pressed !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_held: got %b expected 11", pressed);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({pressed, press_pulse, release_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_async_drop: got %b expected 000000", {pressed, press_pulse, release_pulse});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (press_pulse !== ((k == 5) ? 2'b11 : 2'b00) || release_pulse !== 2'b00 ||
          pressed !== ((k >= 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL reset_repress edge%0d: got p=%b pp=%b rp=%b expected p=%b pp=%b rp=00",
                 k, pressed, press_pulse, release_pulse,
                 (k >= 5) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00);
      end
    end
    btn_raw = 2'b11;
    wait_edges(8);
    checks++;
    if (pressed !== 2'b00) begin
      errors++;
      $display("FAIL reset_cleanup: got %b expected 00", pressed);
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    btn_raw[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (pressed !== {1'b0, k >= 5} || press_pulse !== {1'b0, k == 5} || release_pulse !== 2'b00) begin
        errors++;
        $display("FAIL clean_press edge%0d: got p=%b pp=%b rp=%b expected p=%b pp=%b rp=00",
                 k, pressed, press_pulse, release_pulse, {1'b0, k >= 5}, {1'b0, k == 5});
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    btn_raw[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (pressed !== {1'b0, k < 5} || release_pulse !== {1'b0, k == 5} || press_pulse !== 2'b00) begin
        errors++;
        $display("FAIL release edge%0d: got p=%b pp=%b rp=%b expected p=%b pp=00 rp=%b",
                 k, pressed, press_pulse, release_pulse, {1'b0, k < 5}, {1'b0, k == 5});
      end
    end
  endtask

  task automatic test_bounce();
    logic [13:0] pat;
    int          bad;
    int          npress;
    // Applied LSB first: low 3, high 1, low 3, then high.
    pat = 14'b11111110001000;
    bad = 0;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      btn_raw[0] = pat[k];
      wait_edges(1);
      if (pressed[0] !== 1'b0 || press_pulse[0] !== 1'b0 || release_pulse[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_reject: got %0d glitching cycles expected 0", bad);
    end
    npress = 0;
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_edges(1);
      if (press_pulse[0] === 1'b1) npress++;
    end
    checks++;
    if (npress != 1 || pressed[0] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_then_hold: got %0d pulses pressed=%b expected 1 pulse pressed=1",
               npress, pressed[0]);
    end
    btn_raw[0] = 1'b1;
    wait_edges(8);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    btn_raw = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (press_pulse !== ((k == 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_press edge%0d: got %b expected %b", k, press_pulse, (k == 5) ? 2'b11 : 2'b00);
      end
    end
    btn_raw = 2'b11;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (release_pulse !== ((k == 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_release edge%0d: got %b expected %b", k, release_pulse, (k == 5) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_random();
    int hold [NB];
    int nerr;
    int npulse;
    nerr   = 0;
    npulse = 0;
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn_raw[ch] = 1'($urandom_range(0, 1));
          hold[ch]    = int'($urandom_range(1, 7));
        end
        hold[ch]--;
      end
      wait_edges(1);
      checks++;
      if (pressed !== m_pressed || press_pulse !== m_pp || release_pulse !== m_rp ||
          (press_pulse & release_pulse) !== 2'b00) begin
        errors++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL random cyc%0d: got p=%b pp=%b rp=%b expected p=%b pp=%b rp=%b",
                   cyc, pressed, press_pulse, release_pulse, m_pressed, m_pp, m_rp);
      end
      if (m_pp != 0 || m_rp != 0) npulse++;
    end
    checks++;
    if (npulse == 0) begin
      errors++;
      $display("FAIL random_activity: got 0 pulse cycles expected >0");
    end
    btn_raw = 2'b11;
    wait_edges(10);
  endtask

  task automatic test_polarity();
    checks++;
    if (pressed2 !== 2'b00) begin
      errors++;
      $display("FAIL polarity_idle: got %b expected 00", pressed2);
    end
    btn2[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (press_pulse2 !== {1'b0, k == 5} || pressed2 !== {1'b0, k >= 5}) begin
        errors++;
        $display("FAIL polarity_press edge%0d: got p=%b pp=%b expected p=%b pp=%b",
                 k, pressed2, press_pulse2, {1'b0, k >= 5}, {1'b0, k == 5});
      end
    end
    btn2[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      wait_edges(1);
      checks++;
      if (release_pulse2 !== {1'b0, k == 5} || pressed2 !== {1'b0, k < 5}) begin
        errors++;
        $display("FAIL polarity_release edge%0d: got p=%b rp=%b expected p=%b rp=%b",
                 k, pressed2, release_pulse2, {1'b0, k < 5}, {1'b0, k == 5});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 2'b11;
    btn2    = 2'b00;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_random();
    test_polarity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
